// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared definitions for the dinosaur game pipeline:
//   - state_t      : game state encoding (IDLE, RUN, PAUSED, OVER)
//   - COLOR_FG/BG  : RGB444 sprite and background colours
//   - screen constants (ground row, dinosaur column span)
//   - SCORE_MAX    : saturation value of the 4-digit BCD score
//   - bcd_digit_inc: single BCD digit increment with wrap 9 -> 0
// -----------------------------------------------------------------------------
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [11:0] COLOR_FG = 12'h555;
    localparam logic [11:0] COLOR_BG = 12'hFFF;

    localparam int GROUND_ROW   = 402;
    localparam int DINO_COL_MIN = 80;
    localparam int DINO_COL_MAX = 161;

    localparam logic [15:0] SCORE_MAX = 16'h9999;

    function automatic logic [3:0] bcd_digit_inc(input logic [3:0] digit);
        return (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD up-counter with synchronous clear and saturation at 9999.
// Ports:
//   clk   in   clock, posedge
//   rst_n in   asynchronous active-low reset, clears value
//   clr   in   synchronous clear (wins over inc)
//   inc   in   add one in BCD with per-digit carry; ignored when saturated
//   value out  current count, digit 3 in [15:12]
//   sat   out  high while value == 9999
// -----------------------------------------------------------------------------
module bcd_counter4
    import dino_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value,
    output logic        sat
);

    logic [15:0] value_next;
    logic        carry;

    assign sat = (value == SCORE_MAX);

    // Ripple the carry from digit 0 upward; a digit only moves if every
    // lower digit was 9 and wrapped.
    always_comb begin
        value_next = value;
        carry      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                value_next[4*i +: 4] = bcd_digit_inc(value[4*i +: 4]);
                carry                = (value[4*i +: 4] == 4'd9);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 16'h0000;
        end else if (clr) begin
            value <= 16'h0000;
        end else if (inc && !sat) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/collision_ctrl.sv
// -----------------------------------------------------------------------------
// collision_ctrl
// Detects dinosaur/obstacle sprite overlap per frame, runs the game state
// machine, keeps the BCD score and produces the registered pixel colour.
// Optional feature: define HISCORE_EN to add a high-score register/output.
// Ports:
//   clk         in   pixel clock, posedge
//   RESET_N     in   asynchronous active-low reset
//   fresh       in   high during active video; falling edge = frame end
//   START       in   start/resume button (level)
//   PAUSE       in   pause button (level)
//   dino_px     in   dinosaur sprite bit of the current pixel
//   cactus_px   in   obstacle sprite bit of the current pixel
//   game_status out  1 while running
//   game_over   out  1 while in OVER
//   score       out  4-digit BCD score
//   rgb         out  registered RGB444 pixel colour
//   hiscore     out  best score seen (HISCORE_EN only)
// -----------------------------------------------------------------------------
module collision_ctrl
    import dino_pkg::*;
#(
    parameter int          FRAMES_PER_POINT = 6,
    parameter int          HIT_MIN_PIXELS   = 4,
    parameter logic [11:0] FG_COLOR         = COLOR_FG,
    parameter logic [11:0] BG_COLOR         = COLOR_BG
)(
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        fresh,
    input  logic        START,
    input  logic        PAUSE,
    input  logic        dino_px,
    input  logic        cactus_px,
    output logic        game_status,
    output logic        game_over,
    output logic [15:0] score,
    output logic [11:0] rgb
`ifdef HISCORE_EN
    ,
    output logic [15:0] hiscore
`endif
);

    localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_POINT - 1);
    localparam logic [9:0] HIT_MIN    = 10'(HIT_MIN_PIXELS);
    localparam logic [9:0] HIT_SAT    = 10'h3FF;

    state_t      state;
    logic        start_d;
    logic        pause_d;
    logic        fresh_d;
    logic [9:0]  hit_cnt;
    logic [5:0]  frame_cnt;
    logic        score_sat;

    logic        start_p;
    logic        pause_p;
    logic        frame_end;
    logic        in_run;
    logic        overlap;
    logic        hit_now;
    logic        restart;
    logic        frame_tick;
    logic        score_inc;

    assign start_p   = START & ~start_d;
    assign pause_p   = PAUSE & ~pause_d;
    assign frame_end = fresh_d & ~fresh;
    assign in_run    = (state == RUN);
    assign overlap   = in_run & dino_px & cactus_px;
    assign hit_now   = frame_end & (hit_cnt >= HIT_MIN);

    // A fresh game (from IDLE or OVER) starts from zero score and counters;
    // resuming from PAUSED keeps them.
    assign restart    = start_p & ((state == IDLE) | (state == OVER));
    assign frame_tick = in_run & frame_end & ~hit_now;
    assign score_inc  = frame_tick & (frame_cnt == FRAME_LAST) & ~score_sat;

    // Edge-detect registers for the buttons and the frame strobe.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            start_d <= 1'b0;
            pause_d <= 1'b0;
            fresh_d <= 1'b0;
        end else begin
            start_d <= START;
            pause_d <= PAUSE;
            fresh_d <= fresh;
        end
    end

    // Game state machine; status outputs are registered alongside the state.
    // In RUN a hit at frame end takes priority over a pause request.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            game_status <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_p) begin
                        state       <= RUN;
                        game_status <= 1'b1;
                    end
                end
                RUN: begin
                    if (hit_now) begin
                        state       <= OVER;
                        game_status <= 1'b0;
                        game_over   <= 1'b1;
                    end else if (pause_p) begin
                        state       <= PAUSED;
                        game_status <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (start_p) begin
                        state       <= RUN;
                        game_status <= 1'b1;
                    end
                end
                OVER: begin
                    if (start_p) begin
                        state       <= RUN;
                        game_status <= 1'b1;
                        game_over   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    game_status <= 1'b0;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

    // Overlap counter. An overlapping pixel in the frame-end cycle itself
    // is carried into the next frame rather than lost.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_cnt <= 10'd0;
        end else if (restart) begin
            hit_cnt <= 10'd0;
        end else if (frame_end) begin
            hit_cnt <= overlap ? 10'd1 : 10'd0;
        end else if (overlap && hit_cnt != HIT_SAT) begin
            hit_cnt <= hit_cnt + 10'd1;
        end
    end

    // Frame counter: one score point per FRAMES_PER_POINT clean RUN frames.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_cnt <= 6'd0;
        end else if (restart) begin
            frame_cnt <= 6'd0;
        end else if (frame_tick) begin
            frame_cnt <= (frame_cnt == FRAME_LAST) ? 6'd0 : frame_cnt + 6'd1;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst_n (RESET_N),
        .clr   (restart),
        .inc   (score_inc),
        .value (score),
        .sat   (score_sat)
    );

    // Composite pixel: any sprite bit paints the foreground colour.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            rgb <= BG_COLOR;
        end else begin
            rgb <= (dino_px | cactus_px) ? FG_COLOR : BG_COLOR;
        end
    end

`ifdef HISCORE_EN
    // Score is frozen on the hit frame, so it can be compared on entry.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            hiscore <= 16'h0000;
        end else if (in_run && hit_now && score > hiscore) begin
            hiscore <= score;
        end
    end
`endif

endmodule

// File: tb/tb_collision_ctrl.sv
// -----------------------------------------------------------------------------
// tb_collision_ctrl
// Directed bench for collision_ctrl. A table of game actions with expected
// status/score drives the main flow; short hand-written sequences cover the
// coincident pause/hit case, the pixel path, BCD carry, asynchronous reset,
// score saturation (on a second instance with one frame per point) and,
// when HISCORE_EN is defined, the high-score register.
// -----------------------------------------------------------------------------
module tb_collision_ctrl;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        fresh, START, PAUSE, dino_px, cactus_px;
    logic        game_status, game_over;
    logic [15:0] score;
    logic [11:0] rgb;
    logic        fresh2, start2, zero_in;
    logic        game_status2, game_over2;
    logic [15:0] score2;
    logic [11:0] rgb2;
`ifdef HISCORE_EN
    logic [15:0] hiscore, hiscore2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    collision_ctrl dut (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .fresh       (fresh),
        .START       (START),
        .PAUSE       (PAUSE),
        .dino_px     (dino_px),
        .cactus_px   (cactus_px),
        .game_status (game_status),
        .game_over   (game_over),
        .score       (score),
        .rgb         (rgb)
`ifdef HISCORE_EN
        , .hiscore   (hiscore)
`endif
    );

    collision_ctrl #(.FRAMES_PER_POINT(1)) dut_fast (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .fresh       (fresh2),
        .START       (start2),
        .PAUSE       (zero_in),
        .dino_px     (zero_in),
        .cactus_px   (zero_in),
        .game_status (game_status2),
        .game_over   (game_over2),
        .score       (score2),
        .rgb         (rgb2)
`ifdef HISCORE_EN
        , .hiscore   (hiscore2)
`endif
    );

    typedef enum {OP_START, OP_PAUSE, OP_FRAMES, OP_HIT} op_t;

    typedef struct {
        op_t         op;
        int          arg;
        logic        exp_status;
        logic        exp_over;
        logic [15:0] exp_score;
    } vec_t;

    typedef struct {
        logic        d;
        logic        c;
        logic [11:0] exp_rgb;
    } px_t;

    vec_t vecs[14];
    px_t  pxv[4];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) begin
            fresh = 1'b1;
            tick();
            fresh = 1'b0;
            tick();
        end
    endtask

    task automatic do_hit(input int n);
        dino_px   = 1'b1;
        cactus_px = 1'b1;
        repeat (n) tick();
        dino_px   = 1'b0;
        cactus_px = 1'b0;
        do_frames(1);
    endtask

    task automatic applyStimulus(input op_t op, input int arg);
        case (op)
            OP_START: begin
                START = 1'b1; tick(); START = 1'b0; tick();
            end
            OP_PAUSE: begin
                PAUSE = 1'b1; tick(); PAUSE = 1'b0; tick();
            end
            OP_FRAMES: do_frames(arg);
            OP_HIT:    do_hit(arg);
            default: ;
        endcase
    endtask

    task automatic do_frames2(input int n);
        for (int i = 0; i < n; i++) begin
            fresh2 = 1'b1;
            tick();
            fresh2 = 1'b0;
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{OP_START,  0,  1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{OP_FRAMES, 12, 1'b1, 1'b0, 16'h0002};
        vecs[2]  = '{OP_HIT,    3,  1'b1, 1'b0, 16'h0002};
        vecs[3]  = '{OP_FRAMES, 5,  1'b1, 1'b0, 16'h0003};
        vecs[4]  = '{OP_HIT,    4,  1'b0, 1'b1, 16'h0003};
        vecs[5]  = '{OP_FRAMES, 6,  1'b0, 1'b1, 16'h0003};
        vecs[6]  = '{OP_PAUSE,  0,  1'b0, 1'b1, 16'h0003};
        vecs[7]  = '{OP_START,  0,  1'b1, 1'b0, 16'h0000};
        vecs[8]  = '{OP_PAUSE,  0,  1'b0, 1'b0, 16'h0000};
        vecs[9]  = '{OP_FRAMES, 12, 1'b0, 1'b0, 16'h0000};
        vecs[10] = '{OP_HIT,    5,  1'b0, 1'b0, 16'h0000};
        vecs[11] = '{OP_START,  0,  1'b1, 1'b0, 16'h0000};
        vecs[12] = '{OP_FRAMES, 6,  1'b1, 1'b0, 16'h0001};
        vecs[13] = '{OP_START,  0,  1'b1, 1'b0, 16'h0001};

        pxv[0] = '{1'b1, 1'b0, 12'h555};
        pxv[1] = '{1'b0, 1'b1, 12'h555};
        pxv[2] = '{1'b1, 1'b1, 12'h555};
        pxv[3] = '{1'b0, 1'b0, 12'hFFF};

        RESET_N = 1'b0;
        fresh = 1'b0; START = 1'b0; PAUSE = 1'b0;
        dino_px = 1'b0; cactus_px = 1'b0;
        fresh2 = 1'b0; start2 = 1'b0; zero_in = 1'b0;
        repeat (3) tick();
        RESET_N = 1'b1;
        tick();

        // Reset state
        checkOutput("reset_status", 16'(game_status), 16'h0);
        checkOutput("reset_over",   16'(game_over),   16'h0);
        checkOutput("reset_score",  score,            16'h0000);
        checkOutput("reset_rgb",    16'(rgb),         16'h0FFF);

        // Main game flow from the action table
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].op, vecs[i].arg);
            checkOutput($sformatf("vec%0d_status", i), 16'(game_status), 16'(vecs[i].exp_status));
            checkOutput($sformatf("vec%0d_over",   i), 16'(game_over),   16'(vecs[i].exp_over));
            checkOutput($sformatf("vec%0d_score",  i), score,            vecs[i].exp_score);
        end

        // Hit and pause on the same frame end: hit wins
        dino_px = 1'b1; cactus_px = 1'b1;
        repeat (4) tick();
        dino_px = 1'b0; cactus_px = 1'b0;
        fresh = 1'b1;
        tick();
        fresh = 1'b0;
        PAUSE = 1'b1;
        #1;
        checkOutput("coinc_before_status", 16'(game_status), 16'h1);
        tick();
        PAUSE = 1'b0;
        checkOutput("coinc_over",   16'(game_over),   16'h1);
        checkOutput("coinc_status", 16'(game_status), 16'h0);
        checkOutput("coinc_score",  score,            16'h0001);
        tick();

        // Pixel path, one cycle latency
        for (int i = 0; i < 4; i++) begin
            dino_px   = pxv[i].d;
            cactus_px = pxv[i].c;
            tick();
            checkOutput($sformatf("px%0d_rgb", i), 16'(rgb), 16'(pxv[i].exp_rgb));
        end
        dino_px = 1'b0; cactus_px = 1'b0;
        tick();
        checkOutput("px_over_hold", 16'(game_over), 16'h1);

        // BCD carry across three digits
        applyStimulus(OP_START, 0);
        checkOutput("roll_restart_score", score, 16'h0000);
        do_frames(999 * 6);
        checkOutput("roll_0999", score, 16'h0999);
        do_frames(6);
        checkOutput("roll_1000", score, 16'h1000);

        // Asynchronous reset in the middle of RUN
        dino_px = 1'b1;
        tick();
        checkOutput("rgb_fg_run", 16'(rgb), 16'h0555);
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("areset_status", 16'(game_status), 16'h0);
        checkOutput("areset_score",  score,            16'h0000);
        checkOutput("areset_rgb",    16'(rgb),         16'h0FFF);
        dino_px = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        checkOutput("areset_idle_after", 16'(game_status), 16'h0);

`ifdef HISCORE_EN
        applyStimulus(OP_START, 0);
        do_frames(15 * 6);
        checkOutput("hs_game1_score", score, 16'h0015);
        do_hit(4);
        checkOutput("hs_game1_over", 16'(game_over), 16'h1);
        checkOutput("hs_after1", hiscore, 16'h0015);
        applyStimulus(OP_START, 0);
        checkOutput("hs_survives_start", hiscore, 16'h0015);
        do_frames(7 * 6);
        do_hit(4);
        checkOutput("hs_game2_score", score, 16'h0007);
        checkOutput("hs_after2", hiscore, 16'h0015);
        RESET_N = 1'b0;
        #1;
        checkOutput("hs_reset", hiscore, 16'h0000);
        tick();
        RESET_N = 1'b1;
        tick();
`endif

        // Score saturation on the one-frame-per-point instance
        start2 = 1'b1; tick(); start2 = 1'b0; tick();
        checkOutput("fast_status", 16'(game_status2), 16'h1);
        do_frames2(9998);
        checkOutput("fast_9998", score2, 16'h9998);
        do_frames2(1);
        checkOutput("fast_9999", score2, 16'h9999);
        do_frames2(6);
        checkOutput("fast_sat", score2, 16'h9999);
        checkOutput("fast_still_run", 16'(game_status2), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collision_ctrl.md
Name: collision_ctrl

Overview:
- Sits directly downstream of the dinosaur jump sprite stage, the obstacle stage and the VGA scan generator.
- Consumes the per-pixel sprite bits (dino_px, cactus_px) and detects dino/obstacle overlap per frame.
- Runs the game state machine that drives game_status back to the jump and obstacle stages.
- Keeps the BCD score and produces the registered composite pixel colour for the VGA output.

Parameters:
- FRAMES_PER_POINT, 6: RUN frames per score increment (range 1..63).
- HIT_MIN_PIXELS, 4: overlapping pixels per frame needed to register a hit (range 1..1023).
- FG_COLOR, 12'h555: RGB444 colour of any sprite pixel.
- BG_COLOR, 12'hFFF: RGB444 background colour.

Ports:
- clk  in  1  pixel clock (clkdiv[0] domain); all logic on posedge.
- RESET_N  in  1  asynchronous active-low reset.
- fresh  in  1  frame strobe, synchronous to clk; high during active video; its falling edge marks blanking start.
- START  in  1  debounced start/resume button, level.
- PAUSE  in  1  debounced pause button, level.
- dino_px  in  1  dinosaur sprite bit for the current (row_addr, col_addr).
- cactus_px  in  1  obstacle sprite bit for the same pixel.
- game_status  out  1  1 = running, 0 = idle/paused/over.
- game_over  out  1  1 while in OVER.
- score  out  16  4-digit BCD score, digit 3 in [15:12].
- rgb  out  12  registered composite pixel colour.

Behaviour:
- Reset (RESET_N low, async): state=IDLE, game_status=0, game_over=0, score=16'h0000, rgb=BG_COLOR; all counters and edge registers cleared.
- Edge detection: START, PAUSE and fresh are each registered once. start_p = START & ~START_d; pause_p = PAUSE & ~PAUSE_d; frame_end = fresh_d & ~fresh, a one-cycle pulse.
- States: IDLE, RUN, PAUSED, OVER.
  - IDLE --start_p--> RUN; score cleared.
  - RUN --pause_p--> PAUSED.
  - RUN --frame_end with hit--> OVER.
  - PAUSED --start_p--> RUN.
  - OVER --start_p--> RUN; score, frame counter and hit counter cleared.
  - start_p in RUN is ignored. pause_p outside RUN is ignored.
- Priority when events coincide in RUN: hit-at-frame_end beats pause_p, giving OVER.
- game_status = (state==RUN). game_over = (state==OVER). Both are registered outputs of the state register, so they change the cycle after the triggering pulse.
- Hit counter: 10-bit, saturating at 1023.
  - Increments on each clk where state==RUN, dino_px=1 and cactus_px=1.
  - On frame_end: hit = (count >= HIT_MIN_PIXELS); the counter is then cleared.
  - Overlap pixels coinciding with the frame_end cycle count toward the next frame.
- Frame counter: 6-bit.
  - On frame_end in RUN with no hit, it increments.
  - When it reaches FRAMES_PER_POINT-1 it wraps to 0 and score increments by 1 in BCD with per-digit carry.
  - Score saturates at 16'h9999.
  - Frame counter and score hold in PAUSED, OVER and IDLE.
- Pixel path: rgb <= (dino_px | cactus_px) ? FG_COLOR : BG_COLOR, one clk latency, in every state.
- Reset asserted mid-frame or mid-game returns to IDLE immediately. The first frame_end after release is a normal pulse only if fresh_d was already high.

Optional Feature:
- Macro HISCORE_EN.
- When defined:
  - Adds output hiscore[15:0], reset 16'h0000.
  - On entry to OVER, hiscore <= score if score > hiscore (BCD compare, equivalent to unsigned compare).
  - hiscore survives START; only RESET_N clears it.
- When undefined: the port and register are absent and behaviour is otherwise identical.

Decomposition:
- Shared package dino_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, OVER=2'd3);
  - RGB444 colour constants;
  - screen constants (ground row 402, dino column 80..161).
- One sub-module, bcd_counter4: 4-digit BCD incrementer with inc, clr and sat outputs. It is reused by the score display.

Test Plan:
- Reset, pulse START, then 12 frame_end pulses with no overlap → game_status=1, score=16'h0002, game_over=0.
- In RUN, assert dino_px=cactus_px=1 for 3 cycles, then frame_end → state stays RUN. Repeat with 4 cycles → game_over=1 and game_status=0 the cycle after frame_end; score frozen.
- pause_p and a qualifying hit at the same frame_end → OVER, not PAUSED. Separately, pause_p alone → PAUSED; 12 frames → score unchanged; START → RUN.
- Preload score to 16'h0999 via frames, advance 6 frames → 16'h1000. From 16'h9999, advance 6 frames → stays 16'h9999.
- dino_px=1, cactus_px=0 → rgb=12'h555 one cycle later; both 0 → 12'hFFF; RESET_N low mid-RUN → asynchronously state=IDLE, rgb=12'hFFF.
- HISCORE_EN: game 1 ends at score 16'h0015, game 2 at 16'h0007 → hiscore=16'h0015 after both; RESET_N → 16'h0000.
